node_datapath: RTL
==================

NODE_DATAPATH -- requirements
Module: node_datapath

Interface
REQ-001 Parameters SHALL be: FEATURES, default 3, features per node; FEATURE_BIT_DEPTH, default 10, signed feature width; COEFF_BIT_DEPTH, default 4, signed coefficient width; BIAS_BIT_DEPTH, default 10, signed bias width; ACC_BIT_DEPTH, default 18, signed accumulator width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 feature  input  FEATURE_BIT_DEPTH  signed feature sample for the current term.
REQ-005 node_valid, load_bias, add, mult, is_one, is_zero  input  1 each  per-cycle term controls from the node controller.
REQ-006 coeff  input  COEFF_BIT_DEPTH  signed coefficient, valid one cycle after the corresponding mult.
REQ-007 bias  input  BIAS_BIT_DEPTH  signed node bias, valid while load_bias=1.
REQ-008 child_direction  output  1  decision: 1 if acc >= 0, 0 if acc < 0.
REQ-009 decision_valid  output  1  one-cycle pulse marking a completed node evaluation.
REQ-010 acc  output  ACC_BIT_DEPTH  current accumulator value, signed.
REQ-011 overflow  output  1  sticky flag, set if any accumulation exceeded the ACC range.

Function
REQ-012 FSM states SHALL be IDLE, ACCUM and DECIDE.
- IDLE -> ACCUM on node_valid=1.
- ACCUM -> DECIDE on the first cycle with node_valid=0.
- DECIDE -> ACCUM if node_valid=1; otherwise DECIDE -> IDLE.
REQ-013 In any cycle with node_valid=1 and load_bias=1, acc SHALL load sext(bias) next cycle, and mul_pending SHALL clear.
REQ-014 With node_valid=1, add=1 and is_one=1, sext(feature) SHALL be added to acc the next cycle.
REQ-015 With node_valid=1 and mult=1, feature SHALL be registered into feat_q and mul_pending set; the next cycle coeff*feat_q (full-width signed product) SHALL be added to acc and mul_pending cleared unless mult is again 1.
REQ-016 When the REQ-014 and REQ-015 additions fall in the same cycle, both terms SHALL be summed into acc in that cycle.
REQ-017 is_zero=1 SHALL leave acc unchanged for that term.
REQ-018 load_bias SHALL take priority over any add/product in the same cycle; a pending product SHALL be discarded.
REQ-019 child_direction SHALL be combinational from the registered acc sign and SHALL be stable throughout DECIDE.
REQ-020 decision_valid SHALL be 1 for exactly the one cycle on entering DECIDE.
REQ-021 Latency SHALL be one cycle from the last node_valid=1 cycle to decision_valid, provided no product is pending.
REQ-022 If node_valid falls while mul_pending=1, the product SHALL still be accumulated, and DECIDE entry SHALL be delayed one cycle.
REQ-023 Control inputs SHALL be ignored while node_valid=0, except that the pending product drains.

Reset
REQ-024 reset=1 SHALL immediately force the state to IDLE and set acc=0, feat_q=0, mul_pending=0, decision_valid=0 and overflow=0; child_direction therefore reads 1.
REQ-025 Reset asserted mid-evaluation SHALL discard the partial sum; no decision_valid SHALL follow deassertion until a new node completes.
REQ-026 overflow SHALL clear only on reset or on a load_bias cycle.

Configuration
REQ-027 With NODE_DATAPATH_SAT_EN defined, accumulation SHALL saturate to +(2^(ACC_BIT_DEPTH-1)-1) or -2^(ACC_BIT_DEPTH-1), and overflow SHALL set.
REQ-028 Without NODE_DATAPATH_SAT_EN, accumulation SHALL wrap modulo 2^ACC_BIT_DEPTH, and overflow SHALL still set on signed overflow.

Structure
REQ-029 Package dtree_pkg SHALL hold the default width constants, the FSM state enum and the sign-extension width rule.
REQ-030 The signed multiplier SHALL be a sub-module, node_mult (COEFF x FEATURE, registered-input, combinational product).

Verification
REQ-031 Bias-only node: bias=-5; is_zero on all 3 terms -> acc=-5, child_direction=0, decision_valid pulses once.
REQ-032 Mixed node: bias=10; term0 is_one with feature=7; term1 mult with feature=-3 and coeff=4; term2 is_zero -> acc=5, child_direction=1.
REQ-033 Back-to-back nodes: DECIDE then node_valid=1 with load_bias and bias=0 -> acc reloads to 0; the previous child_direction is held during DECIDE.
REQ-034 Saturation: bias=511; repeated coeff=7 with feature=511 products beyond 2^17-1 -> with NODE_DATAPATH_SAT_EN acc=131071 and overflow=1; without it acc wraps negative and overflow=1.
REQ-035 Reset mid-ACCUM: reset after term1 -> acc=0 at once, no decision_valid; the next node evaluates correctly from its own bias.
REQ-036 Drain: node_valid falls while mul_pending=1 -> the product is added and decision_valid is delayed by one cycle.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared widths, FSM states and sizing helpers for the decision-tree node datapath.
package dtree_pkg;

    localparam int FEATURES_DEF          = 3;
    localparam int FEATURE_BIT_DEPTH_DEF = 10;
    localparam int COEFF_BIT_DEPTH_DEF   = 4;
    localparam int BIAS_BIT_DEPTH_DEF    = 10;
    localparam int ACC_BIT_DEPTH_DEF     = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_e;

    // Full-width signed product of a coefficient and a feature.
    function automatic int prod_width(input int coeff_w, input int feat_w);
        return coeff_w + feat_w;
    endfunction

    // Internal sum width: widest operand plus enough guard bits that the
    // per-cycle sum never wraps before the range check.
    function automatic int sum_width(input int acc_w, input int prod_w, input int features);
        int base;
        int guard;
        base  = (acc_w > prod_w) ? acc_w : prod_w;
        guard = $clog2(features + 1);
        if (guard < 2) guard = 2;
        return base + guard;
    endfunction

endpackage

// File: rtl/node_mult.sv
// Signed coefficient x feature multiplier: feature captured in feat_q, product combinational.
module node_mult
    import dtree_pkg::*;
#(
    parameter int COEFF_BIT_DEPTH   = COEFF_BIT_DEPTH_DEF,
    parameter int FEATURE_BIT_DEPTH = FEATURE_BIT_DEPTH_DEF,
    parameter int PROD_BIT_DEPTH    = prod_width(COEFF_BIT_DEPTH, FEATURE_BIT_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [FEATURE_BIT_DEPTH-1:0] feature_i,
    input  logic [COEFF_BIT_DEPTH-1:0]   coeff_i,
    output logic [PROD_BIT_DEPTH-1:0]    product_o
);

    logic [FEATURE_BIT_DEPTH-1:0] feat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_q <= '0;
        end else if (load_i) begin
            feat_q <= feature_i;
        end
    end

    // Both operands sign-extended to the product width so the low bits are the exact product.
    assign product_o = PROD_BIT_DEPTH'($signed(coeff_i)) * PROD_BIT_DEPTH'($signed(feat_q));

endmodule

// File: rtl/node_datapath.sv
// Decision-tree node evaluator: accumulates bias + feature terms, then emits the sign decision.
// Define NODE_DATAPATH_SAT_EN to saturate the accumulator instead of wrapping.
module node_datapath
    import dtree_pkg::*;
#(
    parameter int FEATURES          = FEATURES_DEF,
    parameter int FEATURE_BIT_DEPTH = FEATURE_BIT_DEPTH_DEF,
    parameter int COEFF_BIT_DEPTH   = COEFF_BIT_DEPTH_DEF,
    parameter int BIAS_BIT_DEPTH    = BIAS_BIT_DEPTH_DEF,
    parameter int ACC_BIT_DEPTH     = ACC_BIT_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FEATURE_BIT_DEPTH-1:0] feature,
    input  logic                         node_valid,
    input  logic                         load_bias,
    input  logic                         add,
    input  logic                         mult,
    input  logic                         is_one,
    input  logic                         is_zero,
    input  logic [COEFF_BIT_DEPTH-1:0]   coeff,
    input  logic [BIAS_BIT_DEPTH-1:0]    bias,
    output logic                         child_direction,
    output logic                         decision_valid,
    output logic [ACC_BIT_DEPTH-1:0]     acc,
    output logic                         overflow
);

    localparam int PW = prod_width(COEFF_BIT_DEPTH, FEATURE_BIT_DEPTH);
    localparam int SW = sum_width(ACC_BIT_DEPTH, PW, FEATURES);

    state_e                   state_q;
    logic                     decision_valid_q;
    logic [ACC_BIT_DEPTH-1:0] acc_q, acc_d;
    logic                     overflow_q, overflow_d;
    logic                     mul_pending_q, mul_pending_d;
    logic                     feat_load;
    logic                     term_add;
    logic [PW-1:0]            product;
    logic signed [SW-1:0]     add_term, mul_term, sum_w;
    logic [SW-ACC_BIT_DEPTH:0] sum_hi;
    logic                     sum_fits;

    node_mult #(
        .COEFF_BIT_DEPTH   (COEFF_BIT_DEPTH),
        .FEATURE_BIT_DEPTH (FEATURE_BIT_DEPTH),
        .PROD_BIT_DEPTH    (PW)
    ) u_mult (
        .clk       (clk),
        .rst       (reset),
        .load_i    (feat_load),
        .feature_i (feature),
        .coeff_i   (coeff),
        .product_o (product)
    );

    // is_zero suppresses both the direct add and the product for the current term.
    assign term_add = node_valid & add & is_one & ~is_zero;
    assign add_term = term_add ? SW'($signed(feature)) : '0;
    assign mul_term = mul_pending_q ? SW'($signed(product)) : '0;
    assign sum_w    = SW'($signed(acc_q)) + add_term + mul_term;
    // The sum fits when every bit above the ACC sign bit repeats it.
    assign sum_hi   = sum_w[SW-1:ACC_BIT_DEPTH-1];
    assign sum_fits = (&sum_hi) | ~(|sum_hi);

    always_comb begin
        acc_d         = acc_q;
        overflow_d    = overflow_q;
        mul_pending_d = 1'b0;
        feat_load     = 1'b0;
        if (node_valid && load_bias) begin
            acc_d      = ACC_BIT_DEPTH'($signed(bias));
            overflow_d = 1'b0;
        end else begin
            feat_load     = node_valid & mult & ~is_zero;
            mul_pending_d = feat_load;
            acc_d         = sum_w[ACC_BIT_DEPTH-1:0];
            if (!sum_fits) begin
                overflow_d = 1'b1;
`ifdef NODE_DATAPATH_SAT_EN
                acc_d = sum_w[SW-1] ? {1'b1, {(ACC_BIT_DEPTH-1){1'b0}}}
                                    : {1'b0, {(ACC_BIT_DEPTH-1){1'b1}}};
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            overflow_q    <= 1'b0;
            mul_pending_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            overflow_q    <= overflow_d;
            mul_pending_q <= mul_pending_d;
        end
    end

    // A pending product holds off DECIDE so the decision sees the drained sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            decision_valid_q <= 1'b0;
        end else begin
            decision_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (node_valid) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (!node_valid && !mul_pending_q) begin
                        state_q          <= DECIDE;
                        decision_valid_q <= 1'b1;
                    end
                end
                DECIDE: begin
                    state_q <= node_valid ? ACCUM : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign acc             = acc_q;
    assign overflow        = overflow_q;
    assign decision_valid  = decision_valid_q;
    assign child_direction = ~acc_q[ACC_BIT_DEPTH-1];

endmodule
